// File: rtl/usb_tx_wire_arbiter_pkg.sv
// Shared USB transmit-side definitions: requester indices, arbiter FSM
// encoding and the idle line symbol.
package usb_tx_wire_arbiter_pkg;

   localparam int REQ_LINECTRL = 0;
   localparam int REQ_TXBYTE   = 1;
   localparam int REQ_RESUME   = 2;
   localparam int NUM_REQ      = REQ_RESUME + 1;

   localparam logic [1:0] SYM_SE0 = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_GAP   = 2'd2
   } arbState_t;

endpackage

// File: rtl/usb_tx_wire_arbiter_prio_enc.sv
// Fixed-priority encoder: reduces a request vector to a one-hot grant for
// the lowest-index active requester (all zeros when nothing is requested).
module usb_fixed_prio_enc #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] i_req,
   output logic [WIDTH-1:0] o_gnt
);

   // Scan from the top down so the lowest set bit is the one that survives.
   always_comb begin
      o_gnt = '0;
      for (int n = WIDTH - 1; n >= 0; n--) begin
         if (i_req[n]) begin
            o_gnt    = '0;
            o_gnt[n] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_tx_wire_arbiter.sv
// Arbitrates the single USB transmit wire driver among three requesters,
// with a non-preemptive grant and a configurable idle gap between owners.
module usb_tx_wire_arbiter
   import usb_tx_wire_arbiter_pkg::*;
#(
   parameter int GAP_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     reqReq,
   output logic [NUM_REQ-1:0]     reqGnt,
   input  logic [NUM_REQ-1:0]     reqWEn,
   input  logic [2*NUM_REQ-1:0]   reqData,
   input  logic [NUM_REQ-1:0]     reqCtrl,
   input  logic [NUM_REQ-1:0]     reqFullSpeedRate,
   output logic [NUM_REQ-1:0]     reqRdy,
   output logic [1:0]             USBWireData,
   output logic                   USBWireCtrl,
   output logic                   USBWireFullSpeedRate,
   output logic                   USBWireWEn,
   input  logic                   USBWireRdy,
   output logic                   protocolErr
);

   localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES - 1);

   arbState_t          r_state;
   arbState_t          w_nextState;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] w_nextGnt;
   logic [NUM_REQ-1:0] w_prioGnt;
   logic [1:0]         r_gapCnt;
   logic [1:0]         w_nextGapCnt;
   logic               r_protocolErr;
   logic               r_fsRate;
   logic               w_ownerDrops;
   logic               w_ownerRate;

   usb_fixed_prio_enc #(
      .WIDTH (NUM_REQ)
   ) u_prioEnc (
      .i_req (reqReq),
      .o_gnt (w_prioGnt)
   );

   assign w_ownerDrops = ~|(reqReq & r_gnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_gapCnt <= 2'd0;
      end else begin
         r_state  <= w_nextState;
         r_gnt    <= w_nextGnt;
         r_gapCnt <= w_nextGapCnt;
      end
   end

   // A drop by the owner always goes through GAP, even if a request is
   // already waiting, so back-to-back owners never share an edge.
   always_comb begin
      w_nextState  = r_state;
      w_nextGnt    = r_gnt;
      w_nextGapCnt = r_gapCnt;
      case (r_state)
         ST_IDLE: begin
            if (|reqReq) begin
               w_nextGnt   = w_prioGnt;
               w_nextState = ST_OWNED;
            end
         end
         ST_OWNED: begin
            if (w_ownerDrops) begin
               w_nextGnt    = '0;
               w_nextState  = ST_GAP;
               w_nextGapCnt = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (r_gapCnt == 2'd0) begin
               w_nextState = ST_IDLE;
            end else begin
               w_nextGapCnt = r_gapCnt - 2'd1;
            end
         end
         default: begin
            w_nextState  = ST_IDLE;
            w_nextGnt    = '0;
            w_nextGapCnt = 2'd0;
         end
      endcase
   end

   // The rate falls back to the remembered value when nobody owns the wire.
   always_comb begin
      USBWireData = SYM_SE0;
      USBWireCtrl = 1'b0;
      USBWireWEn  = 1'b0;
      w_ownerRate = r_fsRate;
      for (int n = 0; n < NUM_REQ; n++) begin
         if (r_gnt[n]) begin
            USBWireData = reqData[2*n +: 2];
            USBWireCtrl = reqCtrl[n];
            USBWireWEn  = reqWEn[n];
            w_ownerRate = reqFullSpeedRate[n];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsRate      <= 1'b0;
         r_protocolErr <= 1'b0;
      end else begin
         r_fsRate <= w_ownerRate;
         if (|(reqWEn & ~r_gnt)) begin
            r_protocolErr <= 1'b1;
         end
      end
   end

   assign USBWireFullSpeedRate = w_ownerRate;
   assign reqGnt               = r_gnt;
   assign reqRdy               = {NUM_REQ{USBWireRdy}} & r_gnt;
   assign protocolErr          = r_protocolErr;

endmodule

// File: tb/tb_usb_tx_wire_arbiter.sv
// Scoreboard bench for the USB transmit wire arbiter: a cycle model predicts
// each cycle's outputs, queues them, and they are compared mid-cycle.
module tb_usb_tx_wire_arbiter;
   import usb_tx_wire_arbiter_pkg::*;

   localparam int GAP = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] reqReq = '0;
   logic [2:0] reqGnt;
   logic [2:0] reqWEn = '0;
   logic [5:0] reqData = '0;
   logic [2:0] reqCtrl = '0;
   logic [2:0] reqFullSpeedRate = '0;
   logic [2:0] reqRdy;
   logic [1:0] USBWireData;
   logic       USBWireCtrl;
   logic       USBWireFullSpeedRate;
   logic       USBWireWEn;
   logic       USBWireRdy = 1'b0;
   logic       protocolErr;

   typedef struct {
      logic [2:0] gnt;
      logic [2:0] rdy;
      logic [1:0] data;
      logic       ctrl;
      logic       rate;
      logic       wen;
      logic       err;
   } expVec_t;

   expVec_t sbQueue[$];

   int vectorCount = 0;
   int miscompareCount = 0;

   logic [2:0] mGnt;
   int         mPhase;
   int         mGapLeft;
   logic       mErr;
   logic       mRate;

   usb_tx_wire_arbiter #(
      .GAP_CYCLES (GAP)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .reqReq               (reqReq),
      .reqGnt               (reqGnt),
      .reqWEn               (reqWEn),
      .reqData              (reqData),
      .reqCtrl              (reqCtrl),
      .reqFullSpeedRate     (reqFullSpeedRate),
      .reqRdy               (reqRdy),
      .USBWireData          (USBWireData),
      .USBWireCtrl          (USBWireCtrl),
      .USBWireFullSpeedRate (USBWireFullSpeedRate),
      .USBWireWEn           (USBWireWEn),
      .USBWireRdy           (USBWireRdy),
      .protocolErr          (protocolErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectorCount++;
      if (obs !== exp) begin
         miscompareCount++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      mGnt     = 3'b000;
      mPhase   = 0;
      mGapLeft = 0;
      mErr     = 1'b0;
      mRate    = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the next one.
   task automatic applyStimulus(input logic [2:0] req, input logic [2:0] wen,
                                input logic [5:0] data, input logic [2:0] ctrl,
                                input logic [2:0] rate, input logic rdy);
      expVec_t e;
      expVec_t got;
      int own;
      int pick;
      reqReq           = req;
      reqWEn           = wen;
      reqData          = data;
      reqCtrl          = ctrl;
      reqFullSpeedRate = rate;
      USBWireRdy       = rdy;
      own = -1;
      for (int n = 0; n < 3; n++) if (mGnt[n]) own = n;
      e.gnt = mGnt;
      e.rdy = rdy ? mGnt : 3'b000;
      e.err = mErr;
      if (own >= 0) begin
         e.data = data[2*own +: 2];
         e.ctrl = ctrl[own];
         e.rate = rate[own];
         e.wen  = wen[own];
      end else begin
         e.data = 2'b00;
         e.ctrl = 1'b0;
         e.rate = mRate;
         e.wen  = 1'b0;
      end
      sbQueue.push_back(e);

      @(negedge clk);
      if (sbQueue.size() == 0) begin
         checkOutput("sbEmpty", 8'd0, 8'd1);
      end else begin
         got = sbQueue.pop_front();
         checkOutput("gnt",  {5'd0, reqGnt},               {5'd0, got.gnt});
         checkOutput("rdy",  {5'd0, reqRdy},               {5'd0, got.rdy});
         checkOutput("data", {6'd0, USBWireData},          {6'd0, got.data});
         checkOutput("ctrl", {7'd0, USBWireCtrl},          {7'd0, got.ctrl});
         checkOutput("rate", {7'd0, USBWireFullSpeedRate}, {7'd0, got.rate});
         checkOutput("wen",  {7'd0, USBWireWEn},           {7'd0, got.wen});
         checkOutput("err",  {7'd0, protocolErr},          {7'd0, got.err});
      end

      if ((wen & ~mGnt) != 3'b000) mErr = 1'b1;
      if (own >= 0) mRate = rate[own];
      case (mPhase)
         0: if (req != 3'b000) begin
               pick = 0;
               for (int n = 2; n >= 0; n--) if (req[n]) pick = n;
               mGnt   = 3'(1 << pick);
               mPhase = 1;
            end
         1: if (!req[own]) begin
               mGnt     = 3'b000;
               mPhase   = 2;
               mGapLeft = GAP;
            end
         default: begin
               mGapLeft--;
               if (mGapLeft == 0) mPhase = 0;
            end
      endcase
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] txReq;
      txReq = 3'(1 << REQ_TXBYTE);
      modelReset();

      #3;
      checkOutput("rstGnt",  {5'd0, reqGnt},   8'd0);
      checkOutput("rstErr",  {7'd0, protocolErr}, 8'd0);
      checkOutput("rstCtrl", {7'd0, USBWireCtrl}, 8'd0);
      checkOutput("rstRate", {7'd0, USBWireFullSpeedRate}, 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Lowest active requester wins; strobe passes through in the same cycle.
      applyStimulus(3'b110, 3'b000, 6'b000000, 3'b000, 3'b000, 1'b0);
      applyStimulus(3'b110, txReq,  6'b000100, 3'b010, 3'b010, 1'b1);
      applyStimulus(3'b111, txReq,  6'b001000, 3'b010, 3'b010, 1'b1);
      applyStimulus(3'b011, 3'b000, 6'b001100, 3'b000, 3'b010, 1'b0);
      // Owner 1 drops with its last strobe still on the wire; gap follows.
      applyStimulus(3'b001, txReq,  6'b000100, 3'b010, 3'b010, 1'b1);
      for (int i = 0; i < GAP + 1; i++)
         applyStimulus(3'b001, 3'b000, 6'b000011, 3'b001, 3'b000, 1'b1);
      applyStimulus(3'b001, 3'b000, 6'b000011, 3'b001, 3'b000, 1'b1);
      applyStimulus(3'b001, 3'b001, 6'b000010, 3'b001, 3'b000, 1'b0);

      // Drop and immediately re-request.
      applyStimulus(3'b000, 3'b000, 6'b000000, 3'b000, 3'b000, 1'b0);
      for (int i = 0; i < GAP + 2; i++)
         applyStimulus(3'b001, 3'b000, 6'b000000, 3'b000, 3'b001, 1'b1);
      applyStimulus(3'b000, 3'b000, 6'b000000, 3'b000, 3'b001, 1'b0);
      for (int i = 0; i < GAP + 1; i++)
         applyStimulus(3'b010, 3'b000, 6'b000000, 3'b000, 3'b000, 1'b0);

      // Non-owner strobe while requester 1 holds the wire.
      applyStimulus(3'b010, 3'b000, 6'b000000, 3'b010, 3'b000, 1'b1);
      applyStimulus(3'b010, 3'b100, 6'b110000, 3'b110, 3'b000, 1'b1);
      for (int i = 0; i < 3; i++)
         applyStimulus(3'b010, 3'b000, 6'b000100, 3'b010, 3'b000, 1'b1);

      // Asynchronous reset mid-ownership with the drive enable high.
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncGnt",  {5'd0, reqGnt},      8'd0);
      checkOutput("asyncCtrl", {7'd0, USBWireCtrl}, 8'd0);
      checkOutput("asyncRdy",  {5'd0, reqRdy},      8'd0);
      checkOutput("asyncErr",  {7'd0, protocolErr}, 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      modelReset();
      applyStimulus(3'b100, 3'b000, 6'b100000, 3'b100, 3'b100, 1'b1);
      applyStimulus(3'b100, 3'b100, 6'b100000, 3'b100, 3'b100, 1'b1);

      for (int i = 0; i < 60; i++)
         applyStimulus(3'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
                       6'($urandom), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed running, expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/usb_tx_wire_arbiter.md
USB_TX_WIRE_ARBITER -- requirements
Module: usb_tx_wire_arbiter

Interface
REQ-001 The block SHALL have one parameter: GAP_CYCLES, default 1, idle cycles (1..3) inserted between one grant release and the next grant.
REQ-002 Port clk, input, 1: single clock; all sequential logic on posedge.
REQ-003 Port rst, input, 1: reset, asynchronous, active-high.
REQ-004 Port reqReq, input, 3: per-requester wire request; bit 0 = line-control, bit 1 = Tx byte engine, bit 2 = resume/test.
REQ-005 Port reqGnt, output, 3: per-requester grant, one-hot or zero.
REQ-006 Port reqWEn, input, 3: per-requester wire write strobe.
REQ-007 Port reqData, input, 6: per-requester 2-bit line symbol; requester n uses bits [2n+1:2n].
REQ-008 Port reqCtrl, input, 3: per-requester drive-enable.
REQ-009 Port reqFullSpeedRate, input, 3: per-requester rate select.
REQ-010 Port reqRdy, output, 3: per-requester wire ready.
REQ-011 Port USBWireData, output, 2: symbol to the wire driver.
REQ-012 Port USBWireCtrl, output, 1: drive-enable to the wire driver.
REQ-013 Port USBWireFullSpeedRate, output, 1: rate to the wire driver.
REQ-014 Port USBWireWEn, output, 1: write strobe to the wire driver.
REQ-015 Port USBWireRdy, input, 1: wire driver ready.
REQ-016 Port protocolErr, output, 1: sticky error flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, OWNED and GAP.
- IDLE: if any reqReq bit is high, register the grant for the lowest-index active requester and go to OWNED; first reqGnt is visible one cycle after reqReq is sampled.
- OWNED: hold the grant while the owner's reqReq stays high; no preemption by higher priority.
- GAP: GAP_CYCLES cycles, then IDLE.
REQ-018 When the owner's reqReq is sampled low, the block SHALL clear reqGnt on the next edge and enter GAP, even if another request (or the same one) is already high that cycle.
REQ-019 The wire outputs SHALL be combinational muxes of the owner's reqData, reqCtrl, reqFullSpeedRate and reqWEn, selected by the registered grant.
REQ-020 The owner's strobe SHALL pass to USBWireWEn with zero latency, including in the cycle its reqReq drops.
REQ-021 With no grant (IDLE, GAP), outputs SHALL be USBWireWEn=0, USBWireCtrl=0, USBWireData=2'b00, and USBWireFullSpeedRate SHALL hold the last owner's value (register, reset 0).
REQ-022 reqRdy[n] SHALL equal USBWireRdy AND reqGnt[n]; non-owners SHALL see 0.
REQ-023 reqWEn from a non-owner SHALL be ignored on the wire.
REQ-024 A reqWEn from a non-owner SHALL set protocolErr on the next edge; protocolErr is cleared only by rst.
REQ-025 The gap counter SHALL be 2 bits, load GAP_CYCLES-1 on GAP entry, and decrement to 0 without wrap.

Reset
REQ-026 While rst is high, asynchronously: state IDLE, reqGnt=0, gap counter 0, protocolErr=0, USBWireFullSpeedRate=0, USBWireWEn=0, USBWireCtrl=0, USBWireData=2'b00, reqRdy=0.
REQ-027 Reset asserted mid-ownership SHALL drop the grant immediately with no GAP.
REQ-028 The first grant after reset release SHALL follow normal IDLE rules.

Structure
REQ-029 A shared USB package SHALL hold the requester index constants (REQ_LINECTRL=0, REQ_TXBYTE=1, REQ_RESUME=2), the FSM state encoding, and the SE0 symbol 2'b00.
REQ-030 One sub-module, usb_fixed_prio_enc (3-bit request to one-hot lowest-index), is natural; the mux and FSM stay in the top module.

Verification
REQ-031 Scenario: reqReq=3'b110 in IDLE -> reqGnt=3'b010 one cycle later; reqData[3:2]=2'b01 with reqWEn[1]=1 -> USBWireData=01, USBWireWEn=1 in the same cycle.
REQ-032 Scenario: owner 1 holds; reqReq[0] rises -> grant stays 3'b010; owner 1 drops -> reqGnt=0 for 1+GAP_CYCLES cycles, then 3'b001.
REQ-033 Scenario: GAP_CYCLES=3, owner drops req and re-requests the next cycle -> exactly 3 GAP cycles, then re-granted.
REQ-034 Scenario: non-owner 2 pulses reqWEn while owner 1 is idle -> USBWireWEn stays 0 and protocolErr=1 until rst.
REQ-035 Scenario: rst pulsed mid-ownership with USBWireCtrl=1 -> reqGnt=0 and USBWireCtrl=0 without waiting for a clock edge.
REQ-036 Scenario: USBWireRdy=1 with owner 0 -> reqRdy=3'b001; with no owner -> reqRdy=3'b000.
